front_panel_programmer: RTL and testbench
=========================================

// Module: front_panel_programmer
// PURPOSE
//  Parametrised single-clock successor to the push-button memory programmer.
//  - Samples a raw step button in the system clock domain; the button is no longer used as a clock.
//  - Supports address load, write with post-increment, and read-step, with wrap detection.
//  - Prefetches mm_q so rd_data always shows the contents of pr_adrs.
//  - Sits between the DE0 switches/buttons and the memory mux, and feeds the 7-seg decoders.
// PARAMETERS
//  ADDR_W          8   memory address width
//  DATA_W          8   memory word width; also the width of sw_data
//  DEBOUNCE_CYCLES 16  consecutive stable synced samples required to accept a button level change
//  RD_LAT          1   memory read latency: cycles from pr_adrs stable to mm_q valid (1..3)
// PORTS
//  clock      in  1       system clock
//  reset_N    in  1       asynchronous reset, active low
//  mode       in  1       1 = program mode, 0 = run mode (block idle)
//  step_btn   in  1       raw push button, active low, asynchronous, bouncy
//  set_adrs   in  1       level; 1 = next step loads the address from sw_data
//  wr_sel     in  1       level; 1 = step writes, 0 = step reads
//  sw_data    in  DATA_W  switch value
//  mm_q       in  DATA_W  memory read data
//  pr_adrs    out ADDR_W  memory address
//  pr_code    out DATA_W  write data
//  pr_wr_en   out 1       write strobe, exactly one cycle per write step
//  rd_data    out DATA_W  captured mm_q at pr_adrs
//  busy       out 1       FSM not in IDLE
//  wrap       out 1       sticky; address incremented from all-ones to 0
// BEHAVIOUR
//  - Reset values: all outputs 0; debounced level = released; FSM = IDLE.
//  - Button path
//    - 2-FF synchroniser on step_btn, then pressed = ~synced.
//    - Debounce counter restarts on any mismatch; level flips after DEBOUNCE_CYCLES matching cycles.
//    - step = 1-cycle pulse on the debounced press edge only; holding the button gives one step.
//  - FSM states: IDLE, WRITE, INC, FETCH.
//    - IDLE, step & mode & set_adrs:
//      pr_adrs <= sw_data[ADDR_W-1:0] (zero-extended if ADDR_W > DATA_W); wrap <= 0; go to FETCH.
//      set_adrs has priority over wr_sel.
//    - IDLE, step & mode & wr_sel: pr_code <= sw_data; go to WRITE.
//    - IDLE, step & mode & ~wr_sel: go to INC.
//    - IDLE, rising edge of mode: go to FETCH, so the display is refreshed on entry.
//    - WRITE: pr_wr_en = 1 for this single cycle (registered, gated by mode); go to INC.
//    - INC: pr_adrs <= pr_adrs + 1, modulo 2^ADDR_W; at all-ones -> 0, set wrap; go to FETCH.
//    - FETCH: wait RD_LAT cycles, capture rd_data <= mm_q; go to IDLE.
//  - Latency, set_adrs/read: step pulse -> rd_data valid after 1 + RD_LAT (+1 INC for read) cycles.
//  - Latency, write: step -> pr_wr_en next cycle; rd_data updated after WRITE + INC + FETCH.
//  - Step pulse while busy: dropped, not queued.
//  - mode = 0 in any state: FSM goes to IDLE next cycle; pr_wr_en is 0 the same cycle.
//    pr_adrs, pr_code and wrap are retained.
//  - Step pulses while mode = 0 are ignored.
//  - Reset asserted mid-operation: immediate return to reset values; no partial write.
//  - pr_adrs/pr_code are stable across the whole pr_wr_en cycle.
// STRUCTURE
//  - Shared package cdec_pkg: CDEC8 defaults ADDR_W = DATA_W = 8.
//  - FSM state encodings stay local to this module.
//  - Sub-module btn_debounce (sync + counter + edge pulse), parameter DEBOUNCE_CYCLES.
//  - Address/data registers and FSM stay in this module.
// TESTING
//  All scenarios use DEBOUNCE_CYCLES = 4, RD_LAT = 1, behavioural memory preloaded with mem[a] = ~a.
//  1. Reset mid-WRITE -> all outputs 0 next edge; no pr_wr_en pulse.
//  2. mode = 1, set_adrs = 1, sw = 0x3C, press -> pr_adrs = 0x3C, rd_data = 0xC3, no pr_wr_en, busy drops.
//  3. At 0x10, wr_sel = 1, sw = 0xA5, press -> one pr_wr_en pulse (adrs 0x10, code 0xA5);
//     then pr_adrs = 0x11, rd_data = 0xEE.
//  4. Raw button toggling every 2 cycles for 30 cycles -> no step;
//     then held low 50 cycles -> exactly one step.
//  5. At 0xFF, read step -> pr_adrs = 0x00, wrap = 1, rd_data = 0xFF;
//     set_adrs load -> wrap = 0.
//  6. mode = 0 press -> no change; mode 0 -> 1 -> FETCH refresh;
//     mode drop during WRITE -> pr_wr_en = 0, IDLE.

Source files
------------

// File: rtl/cdec_pkg.sv
// Shared CDEC8 memory-programmer defaults.
package cdec_pkg;
  localparam int CDEC_ADDR_W          = 8;
  localparam int CDEC_DATA_W          = 8;
  localparam int CDEC_DEBOUNCE_CYCLES = 16;
  localparam int CDEC_RD_LAT          = 1;
endpackage

// File: rtl/btn_debounce.sv
// Synchronises an active-low bouncy button and emits one pulse per accepted press.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset_N,
  input  logic btn_n,
  output logic step
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic          pressed;
  logic          level;
  logic [CW-1:0] cnt;

  assign pressed = ~sync[1];

  // Sync FFs reset to the released (high) level so no phantom press follows reset.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      sync  <= 2'b11;
      level <= 1'b0;
      cnt   <= '0;
      step  <= 1'b0;
    end else begin
      sync <= {sync[0], btn_n};
      step <= 1'b0;
      if (pressed == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= pressed;
        cnt   <= '0;
        step  <= pressed;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/front_panel_programmer.sv
// Front-panel memory programmer: address load, write/post-increment, read-step, prefetch.
module front_panel_programmer
  import cdec_pkg::*;
#(
  parameter int ADDR_W          = CDEC_ADDR_W,
  parameter int DATA_W          = CDEC_DATA_W,
  parameter int DEBOUNCE_CYCLES = CDEC_DEBOUNCE_CYCLES,
  parameter int RD_LAT          = CDEC_RD_LAT
) (
  input  logic              clock,
  input  logic              reset_N,
  input  logic              mode,
  input  logic              step_btn,
  input  logic              set_adrs,
  input  logic              wr_sel,
  input  logic [DATA_W-1:0] sw_data,
  input  logic [DATA_W-1:0] mm_q,
  output logic [ADDR_W-1:0] pr_adrs,
  output logic [DATA_W-1:0] pr_code,
  output logic              pr_wr_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              wrap
);
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_INC, S_FETCH} state_t;

  state_t            state, nxt;
  logic              step, mode_q;
  logic              ld_adrs, ld_code, inc, cap;
  logic [RD_LAT:0]   vld_pipe;
  logic [ADDR_W-1:0] sw_adrs;

  generate
    if (ADDR_W <= DATA_W) begin : g_trunc
      assign sw_adrs = sw_data[ADDR_W-1:0];
    end else begin : g_zext
      assign sw_adrs = {{(ADDR_W-DATA_W){1'b0}}, sw_data};
    end
  endgenerate

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clock  (clock),
    .reset_N(reset_N),
    .btn_n  (step_btn),
    .step   (step)
  );

  assign busy     = (state != S_IDLE);
  assign pr_wr_en = (state == S_WRITE) & mode;

  always_comb begin
    nxt     = state;
    ld_adrs = 1'b0;
    ld_code = 1'b0;
    inc     = 1'b0;
    cap     = 1'b0;
    if (!mode) begin
      nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (step) begin
            if (set_adrs) begin
              ld_adrs = 1'b1;
              nxt     = S_FETCH;
            end else if (wr_sel) begin
              ld_code = 1'b1;
              nxt     = S_WRITE;
            end else begin
              nxt = S_INC;
            end
          end else if (!mode_q) begin
            nxt = S_FETCH;  // entering program mode refreshes the display
          end
        end
        S_WRITE: nxt = S_INC;
        S_INC: begin
          inc = 1'b1;
          nxt = S_FETCH;
        end
        S_FETCH: begin
          if (vld_pipe[RD_LAT]) begin
            cap = 1'b1;
            nxt = S_IDLE;
          end
        end
        default: nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      state    <= S_IDLE;
      mode_q   <= 1'b0;
      pr_adrs  <= '0;
      pr_code  <= '0;
      rd_data  <= '0;
      wrap     <= 1'b0;
      vld_pipe <= '0;
    end else begin
      state  <= nxt;
      mode_q <= mode;
      if (ld_adrs) begin
        pr_adrs <= sw_adrs;
        wrap    <= 1'b0;
      end else if (inc) begin
        pr_adrs <= pr_adrs + 1'b1;
        if (&pr_adrs) wrap <= 1'b1;
      end
      if (ld_code) pr_code <= sw_data;
      if (cap)     rd_data <= mm_q;
      // vld_pipe[k] marks k cycles since pr_adrs settled for this fetch
      if (state != S_FETCH && nxt == S_FETCH)
        vld_pipe <= {{RD_LAT{1'b0}}, 1'b1};
      else if (state == S_FETCH)
        vld_pipe <= {vld_pipe[RD_LAT-1:0], 1'b0};
      else
        vld_pipe <= '0;
    end
  end
endmodule

// File: tb/tb_front_panel_programmer.sv
// Self-checking bench: randomized front-panel steps against a behavioural memory/programmer model.
module tb_front_panel_programmer;
  logic       clock = 1'b0;
  logic       reset_N = 1'b0;
  logic       mode = 1'b0, step_btn = 1'b1, set_adrs = 1'b0, wr_sel = 1'b0;
  logic [7:0] sw_data = '0, mm_q;
  logic [7:0] pr_adrs, pr_code, rd_data;
  logic       pr_wr_en, busy, wrap;

  int errors = 0, checks = 0;
  int wr_cnt = 0;
  logic [7:0] last_wa, last_wc;
  logic [7:0] mem [256];

  // reference model state
  logic [7:0] ref_mem [256];
  logic [7:0] m_adrs, m_code, m_rd;
  logic       m_wrap;

  front_panel_programmer #(.ADDR_W(8), .DATA_W(8), .DEBOUNCE_CYCLES(4), .RD_LAT(1)) dut (
    .clock(clock), .reset_N(reset_N), .mode(mode), .step_btn(step_btn),
    .set_adrs(set_adrs), .wr_sel(wr_sel), .sw_data(sw_data), .mm_q(mm_q),
    .pr_adrs(pr_adrs), .pr_code(pr_code), .pr_wr_en(pr_wr_en),
    .rd_data(rd_data), .busy(busy), .wrap(wrap)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (pr_wr_en) begin
      mem[pr_adrs] <= pr_code;
      wr_cnt  <= wr_cnt + 1;
      last_wa <= pr_adrs;
      last_wc <= pr_code;
    end
    mm_q <= mem[pr_adrs];
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic model_reset();
    m_adrs = '0; m_code = '0; m_rd = '0; m_wrap = 1'b0;
  endtask

  task automatic model_step(input bit s, input bit w, input logic [7:0] sw);
    if (s) begin
      m_adrs = sw;
      m_wrap = 1'b0;
    end else begin
      if (w) begin
        ref_mem[m_adrs] = sw;
        m_code = sw;
      end
      if (m_adrs == 8'hFF) m_wrap = 1'b1;
      m_adrs = m_adrs + 8'd1;
    end
    m_rd = ref_mem[m_adrs];
  endtask

  task automatic press(input bit s, input bit w, input logic [7:0] sw);
    set_adrs = s; wr_sel = w; sw_data = sw;
    step_btn = 1'b0; cyc(10);
    step_btn = 1'b1; cyc(10);
  endtask

  task automatic test_reset();
    @(negedge clock);
    checks++;
    if ({pr_adrs, pr_code, rd_data, pr_wr_en, busy, wrap} !== 27'd0) begin
      errors++;
      $display("FAIL reset_state: got adrs=%h code=%h rd=%h we=%b busy=%b wrap=%b, want all 0",
               pr_adrs, pr_code, rd_data, pr_wr_en, busy, wrap);
    end
    cyc(1); reset_N = 1'b1; mode = 1'b1;
    model_reset(); m_rd = ref_mem[0];
    cyc(6);
    @(negedge clock);
    checks++;
    if ({pr_adrs, rd_data, busy} !== {m_adrs, m_rd, 1'b0}) begin
      errors++;
      $display("FAIL mode_entry_refresh: got adrs=%h rd=%h busy=%b, want adrs=%h rd=%h busy=0",
               pr_adrs, rd_data, busy, m_adrs, m_rd);
    end
  endtask

  task automatic test_reset_mid_write();
    int w0, n;
    bit seen;
    w0 = wr_cnt; seen = 0;
    set_adrs = 0; wr_sel = 1; sw_data = 8'h5A; step_btn = 1'b0;
    for (n = 0; n < 20 && !seen; n++) begin
      @(negedge clock);
      if (busy) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rst_write_start: got busy=0, want busy=1 within 20 cycles"); end
    reset_N = 1'b0;
    #1;
    checks++;
    if ({pr_adrs, pr_code, rd_data, pr_wr_en, busy, wrap} !== 27'd0) begin
      errors++;
      $display("FAIL rst_mid_write_outputs: got adrs=%h code=%h rd=%h we=%b busy=%b wrap=%b, want all 0",
               pr_adrs, pr_code, rd_data, pr_wr_en, busy, wrap);
    end
    step_btn = 1'b1; cyc(10);
    checks++;
    if (wr_cnt !== w0 || mem[0] !== ref_mem[0]) begin
      errors++;
      $display("FAIL rst_no_write: got writes=%0d mem0=%h, want writes=%0d mem0=%h",
               wr_cnt - w0, mem[0], 0, ref_mem[0]);
    end
    reset_N = 1'b1;
    model_reset(); m_rd = ref_mem[0];
    cyc(6);
  endtask

  task automatic test_load();
    int w0;
    w0 = wr_cnt;
    press(1, 0, 8'h3C); model_step(1, 0, 8'h3C);
    @(negedge clock);
    checks++;
    if ({pr_adrs, rd_data, busy, wrap} !== {m_adrs, m_rd, 1'b0, m_wrap} || wr_cnt !== w0) begin
      errors++;
      $display("FAIL load_3c: got adrs=%h rd=%h busy=%b wrap=%b writes=%0d, want adrs=%h rd=%h busy=0 wrap=%b writes=0",
               pr_adrs, rd_data, busy, wrap, wr_cnt - w0, m_adrs, m_rd, m_wrap);
    end
  endtask

  task automatic test_write();
    int w0;
    press(1, 0, 8'h10); model_step(1, 0, 8'h10);
    w0 = wr_cnt;
    press(0, 1, 8'hA5); model_step(0, 1, 8'hA5);
    @(negedge clock);
    checks++;
    if (wr_cnt - w0 !== 1 || last_wa !== 8'h10 || last_wc !== 8'hA5) begin
      errors++;
      $display("FAIL write_pulse: got pulses=%0d adrs=%h code=%h, want pulses=1 adrs=10 code=a5",
               wr_cnt - w0, last_wa, last_wc);
    end
    checks++;
    if ({pr_adrs, pr_code, rd_data, wrap} !== {m_adrs, m_code, m_rd, m_wrap}) begin
      errors++;
      $display("FAIL write_post_inc: got adrs=%h code=%h rd=%h wrap=%b, want adrs=%h code=%h rd=%h wrap=%b",
               pr_adrs, pr_code, rd_data, wrap, m_adrs, m_code, m_rd, m_wrap);
    end
  endtask

  task automatic test_debounce();
    bit any_busy;
    logic [7:0] a0;
    any_busy = 0; a0 = pr_adrs;
    set_adrs = 0; wr_sel = 0;
    for (int i = 0; i < 15; i++) begin
      step_btn = ~step_btn; cyc(1);
      @(negedge clock); if (busy) any_busy = 1;
      #2;
    end
    step_btn = 1'b1; cyc(10);
    checks++;
    if (any_busy || pr_adrs !== a0) begin
      errors++;
      $display("FAIL bounce_no_step: got busy_seen=%b adrs=%h, want busy_seen=0 adrs=%h", any_busy, pr_adrs, a0);
    end
    step_btn = 1'b0; cyc(50);
    step_btn = 1'b1; cyc(10);
    model_step(0, 0, 8'h00);
    @(negedge clock);
    checks++;
    if ({pr_adrs, rd_data} !== {m_adrs, m_rd}) begin
      errors++;
      $display("FAIL hold_one_step: got adrs=%h rd=%h, want adrs=%h rd=%h", pr_adrs, rd_data, m_adrs, m_rd);
    end
  endtask

  task automatic test_wrap();
    press(1, 0, 8'hFF); model_step(1, 0, 8'hFF);
    press(0, 0, 8'h00); model_step(0, 0, 8'h00);
    @(negedge clock);
    checks++;
    if ({pr_adrs, rd_data, wrap} !== {m_adrs, m_rd, m_wrap} || wrap !== 1'b1) begin
      errors++;
      $display("FAIL wrap_set: got adrs=%h rd=%h wrap=%b, want adrs=%h rd=%h wrap=%b",
               pr_adrs, rd_data, wrap, m_adrs, m_rd, m_wrap);
    end
    press(1, 0, 8'h05); model_step(1, 0, 8'h05);
    @(negedge clock);
    checks++;
    if ({pr_adrs, wrap} !== {m_adrs, m_wrap}) begin
      errors++;
      $display("FAIL wrap_clear: got adrs=%h wrap=%b, want adrs=%h wrap=%b", pr_adrs, wrap, m_adrs, m_wrap);
    end
  endtask

  task automatic test_mode();
    int w0, n;
    bit seen;
    mode = 1'b0;
    press(1, 0, 8'h77);
    @(negedge clock);
    checks++;
    if ({pr_adrs, rd_data, busy} !== {m_adrs, m_rd, 1'b0}) begin
      errors++;
      $display("FAIL mode0_ignored: got adrs=%h rd=%h busy=%b, want adrs=%h rd=%h busy=0",
               pr_adrs, rd_data, busy, m_adrs, m_rd);
    end
    cyc(1); mode = 1'b1; seen = 0;
    for (n = 0; n < 4 && !seen; n++) begin @(negedge clock); if (busy) seen = 1; end
    checks++;
    if (!seen) begin errors++; $display("FAIL mode_rise_fetch: got busy=0, want busy=1 within 4 cycles"); end
    cyc(5);
    w0 = wr_cnt; seen = 0;
    set_adrs = 0; wr_sel = 1; sw_data = 8'h99; step_btn = 1'b0;
    for (n = 0; n < 20 && !seen; n++) begin @(negedge clock); if (busy) seen = 1; end
    mode = 1'b0;
    #1;
    checks++;
    if (!seen || pr_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL mode_drop_we: got busy_seen=%b we=%b, want busy_seen=1 we=0", seen, pr_wr_en);
    end
    m_code = 8'h99;
    step_btn = 1'b1; cyc(10);
    @(negedge clock);
    checks++;
    if ({pr_adrs, pr_code, busy, wrap} !== {m_adrs, m_code, 1'b0, m_wrap} || wr_cnt !== w0) begin
      errors++;
      $display("FAIL mode_drop_idle: got adrs=%h code=%h busy=%b wrap=%b writes=%0d, want adrs=%h code=%h busy=0 wrap=%b writes=0",
               pr_adrs, pr_code, busy, wrap, wr_cnt - w0, m_adrs, m_code, m_wrap);
    end
    cyc(1); mode = 1'b1; cyc(8);
  endtask

  task automatic test_random();
    bit s, w;
    logic [7:0] sw;
    for (int i = 0; i < 24; i++) begin
      s  = ($urandom_range(0, 3) == 0);
      w  = $urandom_range(0, 1);
      sw = 8'($urandom);
      if (i == 0) begin s = 1; sw = 8'hFD; end
      press(s, w, sw); model_step(s, w, sw);
      @(negedge clock);
      checks++;
      if ({pr_adrs, pr_code, rd_data, wrap, busy} !== {m_adrs, m_code, m_rd, m_wrap, 1'b0}) begin
        errors++;
        $display("FAIL random_%0d: got adrs=%h code=%h rd=%h wrap=%b busy=%b, want adrs=%h code=%h rd=%h wrap=%b busy=0",
                 i, pr_adrs, pr_code, rd_data, wrap, busy, m_adrs, m_code, m_rd, m_wrap);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      mem[a]     = ~8'(a);
      ref_mem[a] = ~8'(a);
    end
    model_reset();
    cyc(3);
    test_reset();
    test_reset_mid_write();
    test_load();
    test_write();
    test_debounce();
    test_wrap();
    test_mode();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, want finish before 2000000");
    $fatal(1);
  end
endmodule
